// File: rtl/scoreboard_mp.sv
// Multi-port issue scoreboard: in-order allocate, out-of-order writeback, in-order commit.
// Optional SB_WB_BYPASS_EN forwards same-cycle writeback data into the source lookup.
module scoreboard_mp #(
  parameter int unsigned Depth       = 8,
  parameter int unsigned IdxW        = $clog2(Depth),
  parameter int unsigned WbPorts     = 4,
  parameter int unsigned CommitPorts = 2,
  parameter int unsigned NumRs       = 2,
  parameter int unsigned PayloadW    = 64
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            alloc_valid,
  output logic                            alloc_ready,
  input  logic [4:0]                      alloc_rd,
  input  logic                            alloc_we,
  input  logic [PayloadW-1:0]             alloc_payload,
  output logic [IdxW-1:0]                 alloc_id,
  input  logic [WbPorts-1:0]              wb_valid,
  input  logic [WbPorts*IdxW-1:0]         wb_idx,
  input  logic [WbPorts*32-1:0]           wb_data,
  input  logic [WbPorts-1:0]              wb_exc,
  output logic [CommitPorts-1:0]          commit_valid,
  input  logic [CommitPorts-1:0]          commit_ack,
  output logic [CommitPorts*IdxW-1:0]     commit_id,
  output logic [CommitPorts*5-1:0]        commit_rd,
  output logic [CommitPorts-1:0]          commit_we,
  output logic [CommitPorts*32-1:0]       commit_data,
  output logic [CommitPorts-1:0]          commit_exc,
  output logic [CommitPorts*PayloadW-1:0] commit_payload,
  input  logic [NumRs*5-1:0]              rs_addr,
  output logic [NumRs-1:0]                rs_hit,
  output logic [NumRs*IdxW-1:0]           rs_id,
  output logic [NumRs-1:0]                rs_rdy,
  output logic [NumRs*32-1:0]             rs_data
);

  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Depth-1:0]    issued_q, issued_d, done_q, done_d, exc_q, exc_d;
  logic [Depth-1:0]    we_q, we_d;
  logic [4:0]          rd_q      [Depth];
  logic [4:0]          rd_d      [Depth];
  logic [31:0]         data_q    [Depth];
  logic [31:0]         data_d    [Depth];
  logic [PayloadW-1:0] payload_q [Depth];
  logic [PayloadW-1:0] payload_d [Depth];
  logic [IdxW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d, n_ack;
  logic                alloc_fire;

  assign alloc_ready = (count_q != DepthCnt) && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_id    = tail_q;

  always_comb begin
    logic            chain;
    logic [IdxW-1:0] idx;
    chain          = 1'b1;
    commit_valid   = '0;
    commit_id      = '0;
    commit_rd      = '0;
    commit_we      = '0;
    commit_data    = '0;
    commit_exc     = '0;
    commit_payload = '0;
    n_ack          = '0;
    for (int k = 0; k < CommitPorts; k++) begin
      idx   = head_q + IdxW'(k);
      chain = chain && issued_q[idx] && done_q[idx];
      commit_valid[k]                      = chain;
      commit_id[k*IdxW +: IdxW]            = idx;
      commit_rd[k*5 +: 5]                  = rd_q[idx];
      commit_we[k]                         = we_q[idx];
      commit_data[k*32 +: 32]              = data_q[idx];
      commit_exc[k]                        = exc_q[idx];
      commit_payload[k*PayloadW +: PayloadW] = payload_q[idx];
      n_ack = n_ack + CntW'(commit_ack[k]);
    end
  end

  // Order matters: writeback, then commit clears, then allocation into the tail slot.
  always_comb begin
    logic [IdxW-1:0] idx;
    issued_d  = issued_q;
    done_d    = done_q;
    exc_d     = exc_q;
    we_d      = we_q;
    rd_d      = rd_q;
    data_d    = data_q;
    payload_d = payload_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    idx       = '0;
    if (flush) begin
      issued_d = '0;
      done_d   = '0;
      exc_d    = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end else begin
      for (int p = 0; p < WbPorts; p++) begin
        idx = wb_idx[p*IdxW +: IdxW];
        if (wb_valid[p] && issued_q[idx]) begin
          done_d[idx] = 1'b1;
          exc_d[idx]  = wb_exc[p];
          data_d[idx] = wb_data[p*32 +: 32];
        end
      end
      for (int k = 0; k < CommitPorts; k++) begin
        idx = head_q + IdxW'(k);
        if (commit_ack[k]) begin
          issued_d[idx] = 1'b0;
          done_d[idx]   = 1'b0;
        end
      end
      if (alloc_fire) begin
        issued_d[tail_q]  = 1'b1;
        done_d[tail_q]    = 1'b0;
        exc_d[tail_q]     = 1'b0;
        we_d[tail_q]      = alloc_we;
        rd_d[tail_q]      = alloc_rd;
        payload_d[tail_q] = alloc_payload;
        tail_d            = tail_q + 1'b1;
      end
      head_d  = head_q + n_ack[IdxW-1:0];
      count_d = count_q + CntW'(alloc_fire) - n_ack;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_q <= '0;
      done_q   <= '0;
      exc_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      issued_q <= issued_d;
      done_q   <= done_d;
      exc_q    <= exc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    we_q      <= we_d;
    rd_q      <= rd_d;
    data_q    <= data_d;
    payload_q <= payload_d;
  end

  // Walking from head upward, later matches are younger and overwrite older ones.
  always_comb begin
    logic [IdxW-1:0] idx;
    logic [4:0]      addr;
    rs_hit  = '0;
    rs_id   = '0;
    rs_rdy  = '0;
    rs_data = '0;
    for (int r = 0; r < NumRs; r++) begin
      addr = rs_addr[r*5 +: 5];
      for (int i = 0; i < Depth; i++) begin
        idx = head_q + IdxW'(i);
        if (issued_q[idx] && we_q[idx] && (rd_q[idx] == addr) && (addr != 5'd0)) begin
          rs_hit[r]               = 1'b1;
          rs_id[r*IdxW +: IdxW]   = idx;
          rs_rdy[r]               = done_q[idx];
          rs_data[r*32 +: 32]     = data_q[idx];
        end
      end
`ifdef SB_WB_BYPASS_EN
      if (rs_hit[r] && !rs_rdy[r]) begin
        for (int p = 0; p < WbPorts; p++) begin
          if (wb_valid[p] && (wb_idx[p*IdxW +: IdxW] == rs_id[r*IdxW +: IdxW])) begin
            rs_rdy[r]           = 1'b1;
            rs_data[r*32 +: 32] = wb_data[p*32 +: 32];
          end
        end
      end
`endif
    end
  end

  logic ack_legal;
  always_comb begin
    ack_legal = 1'b1;
    for (int k = 0; k < CommitPorts; k++) begin
      if (commit_ack[k] && !commit_valid[k]) ack_legal = 1'b0;
      if (k > 0 && commit_ack[k] && !commit_ack[k-1]) ack_legal = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      assert (ack_legal) else $error("commit_ack is not a prefix of commit_valid");
    end
  end

endmodule

// File: tb/tb_scoreboard_mp.sv
// Self-checking bench for scoreboard_mp: directed plan plus randomized traffic
// compared each cycle against an in-order queue model of in-flight instructions.
module tb_scoreboard_mp;
  localparam int DEPTH = 8;
  localparam int IDXW  = 3;
  localparam int WBP   = 4;
  localparam int CP    = 2;
  localparam int NRS   = 2;
  localparam int PLW   = 64;

  logic             clock, reset, flush;
  logic             alloc_valid, alloc_ready, alloc_we;
  logic [4:0]       alloc_rd;
  logic [PLW-1:0]   alloc_payload;
  logic [IDXW-1:0]  alloc_id;
  logic [WBP-1:0]   wb_valid, wb_exc;
  logic [WBP*IDXW-1:0] wb_idx;
  logic [WBP*32-1:0]   wb_data;
  logic [CP-1:0]    commit_valid, commit_ack, commit_we, commit_exc;
  logic [CP*IDXW-1:0] commit_id;
  logic [CP*5-1:0]  commit_rd;
  logic [CP*32-1:0] commit_data;
  logic [CP*PLW-1:0] commit_payload;
  logic [NRS*5-1:0] rs_addr;
  logic [NRS-1:0]   rs_hit, rs_rdy;
  logic [NRS*IDXW-1:0] rs_id;
  logic [NRS*32-1:0] rs_data;

  scoreboard_mp #(.Depth(DEPTH), .IdxW(IDXW), .WbPorts(WBP), .CommitPorts(CP),
                  .NumRs(NRS), .PayloadW(PLW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
    .alloc_we(alloc_we), .alloc_payload(alloc_payload), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .wb_exc(wb_exc),
    .commit_valid(commit_valid), .commit_ack(commit_ack), .commit_id(commit_id),
    .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
    .commit_exc(commit_exc), .commit_payload(commit_payload),
    .rs_addr(rs_addr), .rs_hit(rs_hit), .rs_id(rs_id), .rs_rdy(rs_rdy), .rs_data(rs_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] pl;
    logic        done;
    logic [31:0] data;
    logic        exc;
  } ent_t;

  ent_t q[$];
  int   tail_m;
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    flush = 0; alloc_valid = 0; alloc_we = 0; alloc_rd = '0; alloc_payload = '0;
    wb_valid = '0; wb_idx = '0; wb_data = '0; wb_exc = '0; commit_ack = '0;
  endtask

  task automatic set_wb(input int p, input int idx, input logic [31:0] d, input logic e);
    wb_valid[p] = 1'b1;
    wb_idx[p*IDXW +: IDXW] = IDXW'(idx);
    wb_data[p*32 +: 32] = d;
    wb_exc[p] = e;
  endtask

  // Expected outputs from the in-flight queue and the current inputs.
  task automatic check_model();
    logic pre;
    chk("alloc_ready", alloc_ready, (q.size() != DEPTH) && !flush);
    chk("alloc_id", alloc_id, tail_m);
    pre = 1'b1;
    for (int k = 0; k < CP; k++) begin
      if (k < q.size()) pre = pre && q[k].done;
      else pre = 1'b0;
      chk("commit_valid", commit_valid[k], pre);
      if (pre) begin
        chk("commit_id", commit_id[k*IDXW +: IDXW], q[k].id);
        chk("commit_rd", commit_rd[k*5 +: 5], q[k].rd);
        chk("commit_we", commit_we[k], q[k].we);
        chk("commit_data", commit_data[k*32 +: 32], q[k].data);
        chk("commit_exc", commit_exc[k], q[k].exc);
        chk("commit_payload", commit_payload[k*PLW +: PLW], q[k].pl);
      end
    end
    for (int r = 0; r < NRS; r++) begin
      logic [4:0] a;
      int m;
      logic rdy;
      logic [31:0] d;
      a = rs_addr[r*5 +: 5];
      m = -1;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (m < 0 && a != 0 && q[i].we && q[i].rd == a) m = i;
      end
      chk("rs_hit", rs_hit[r], m >= 0);
      if (m >= 0) begin
        rdy = q[m].done;
        d = q[m].data;
`ifdef SB_WB_BYPASS_EN
        if (!rdy) begin
          for (int p = 0; p < WBP; p++) begin
            if (wb_valid[p] && wb_idx[p*IDXW +: IDXW] == IDXW'(q[m].id)) begin
              rdy = 1'b1;
              d = wb_data[p*32 +: 32];
            end
          end
        end
`endif
        chk("rs_id", rs_id[r*IDXW +: IDXW], q[m].id);
        chk("rs_rdy", rs_rdy[r], rdy);
        if (rdy) chk("rs_data", rs_data[r*32 +: 32], d);
      end
    end
  endtask

  task automatic update_model();
    int fire;
    int n;
    if (flush) begin
      q.delete();
      tail_m = 0;
      return;
    end
    fire = alloc_valid && (q.size() != DEPTH);
    for (int p = 0; p < WBP; p++) begin
      if (wb_valid[p]) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].id == int'(wb_idx[p*IDXW +: IDXW])) begin
            q[i].done = 1'b1;
            q[i].data = wb_data[p*32 +: 32];
            q[i].exc  = wb_exc[p];
          end
        end
      end
    end
    n = $countones(commit_ack);
    repeat (n) void'(q.pop_front());
    if (fire != 0) begin
      ent_t e;
      e.id = tail_m; e.rd = alloc_rd; e.we = alloc_we; e.pl = alloc_payload;
      e.done = 1'b0; e.data = '0; e.exc = 1'b0;
      q.push_back(e);
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  // Entered just after inputs are driven (between edges); leaves with idle inputs.
  task automatic cycle();
    #1;
    check_model();
    @(posedge clock);
    update_model();
    @(negedge clock);
    clear_inputs();
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic we);
    alloc_valid = 1; alloc_rd = rd; alloc_we = we;
    alloc_payload = {$urandom, $urandom};
  endtask

  initial begin
    checks = 0; failures = 0; tail_m = 0;
    clear_inputs();
    rs_addr = {5'd3, 5'd1};
    reset = 1'b1;
    #3;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_rs_hit", rs_hit, 0);
    chk("rst_rs_rdy", rs_rdy, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Fill all eight slots, then offer a ninth
    for (int i = 0; i < 8; i++) begin
      alloc(5'(i), 1'b1);
      chk("t1_alloc_id", alloc_id, i);
      cycle();
    end
    chk("t1_ready_full", alloc_ready, 0);
    alloc(5'd9, 1'b1);
    cycle();
    chk("t1_ninth_rejected_id", alloc_id, 0);

    // Full: ack two while offering an alloc
    set_wb(0, 0, 32'h10, 1'b0);
    set_wb(1, 1, 32'h11, 1'b1);
    cycle();
    chk("t3_commit_valid", commit_valid, 2'b11);
    commit_ack = 2'b11;
    alloc(5'd4, 1'b1);
    chk("t3_ready_while_full", alloc_ready, 0);
    cycle();
    chk("t3_ready_after", alloc_ready, 1);
    chk("t3_alloc_id_wrap", alloc_id, 0);
    flush = 1;
    cycle();

    // Out-of-order writeback, in-order commit
    for (int i = 0; i < 3; i++) begin alloc(5'(i + 1), 1'b1); cycle(); end
    set_wb(0, 2, 32'hC, 1'b0); cycle();
    set_wb(0, 0, 32'hA, 1'b0); cycle();
    chk("t2_cv_01", commit_valid, 2'b01);
    chk("t2_id0", commit_id[0 +: IDXW], 0);
    chk("t2_data0", commit_data[0 +: 32], 32'hA);
    commit_ack = 2'b01; cycle();
    set_wb(3, 1, 32'hB, 1'b0); cycle();
    chk("t2_cv_11", commit_valid, 2'b11);
    chk("t2_id0b", commit_id[0 +: IDXW], 1);
    chk("t2_id1", commit_id[IDXW +: IDXW], 2);
    chk("t2_data0b", commit_data[0 +: 32], 32'hB);
    chk("t2_data1", commit_data[32 +: 32], 32'hC);
    commit_ack = 2'b11; cycle();
    flush = 1; cycle();

    // Youngest-producer lookup
    alloc(5'd5, 1'b1); cycle();
    alloc(5'd5, 1'b1); cycle();
    rs_addr = {5'd0, 5'd5};
    #1;
    chk("t4_hit", rs_hit[0], 1);
    chk("t4_id", rs_id[0 +: IDXW], 1);
    chk("t4_rdy", rs_rdy[0], 0);
    chk("t4_hit_r0", rs_hit[1], 0);
`ifdef SB_WB_BYPASS_EN
    set_wb(2, 1, 32'h77, 1'b0);
    #1;
    chk("t6_bypass_rdy", rs_rdy[0], 1);
    chk("t6_bypass_data", rs_data[0 +: 32], 32'h77);
`else
    set_wb(2, 1, 32'h77, 1'b0);
    #1;
    chk("t6_nobypass_rdy", rs_rdy[0], 0);
`endif
    cycle();
    chk("t4_rdy_after_wb", rs_rdy[0], 1);
    chk("t4_data_after_wb", rs_data[0 +: 32], 32'h77);

    // Flush beats alloc and writeback
    flush = 1; cycle();
    for (int i = 0; i < 3; i++) begin alloc(5'd6, 1'b1); cycle(); end
    flush = 1; alloc(5'd7, 1'b1); set_wb(0, 1, 32'h5, 1'b0);
    #1;
    chk("t5_ready_in_flush", alloc_ready, 0);
    cycle();
    chk("t5_alloc_id", alloc_id, 0);
    chk("t5_cv", commit_valid, 0);
    set_wb(0, 1, 32'h6, 1'b0); cycle();
    chk("t5_stale_wb", commit_valid, 0);

    // Randomized traffic with one asynchronous reset mid-stream
    for (int it = 0; it < 3000; it++) begin
      int nv;
      int n;
      if (it == 1500) begin
        alloc(5'd1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_cv", commit_valid, 0);
        chk("t6_async_ready", alloc_ready, 1);
        chk("t6_async_id", alloc_id, 0);
        q.delete();
        tail_m = 0;
        @(negedge clock);
        reset = 1'b0;
        clear_inputs();
        #1;
      end
      if ($urandom_range(0, 99) < 55) alloc(5'($urandom_range(0, 3)), 1'($urandom));
      flush = ($urandom_range(0, 99) < 2);
      for (int p = 0; p < WBP; p++) begin
        if ($urandom_range(0, 99) < 35) begin
          int idx;
          if (q.size() > 0 && $urandom_range(0, 9) < 7)
            idx = q[$urandom_range(0, q.size() - 1)].id;
          else
            idx = $urandom_range(0, DEPTH - 1);
          set_wb(p, idx, $urandom, 1'($urandom));
        end
      end
      nv = 0;
      for (int k = 0; k < CP && k < q.size(); k++) begin
        if (nv == k && q[k].done) nv++;
      end
      n = $urandom_range(0, nv);
      commit_ack = CP'((1 << n) - 1);
      for (int r = 0; r < NRS; r++) rs_addr[r*5 +: 5] = 5'($urandom_range(0, 3));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scoreboard_mp.md
Name: scoreboard_mp

Overview:
- Parametrised successor to the issue-stage scoreboard: in-order allocate, out-of-order writeback, in-order multi-port commit.
- Adds multiple commit ports, flush, exception capture per entry, and a source-register lookup (youngest-producer search) for operand read in the issue stage.
- Sits between decode (allocate side) and the functional units / commit stage.

Parameters:
- Depth, 8, number of entries; power of two, >=2.
- IdxW, $clog2(Depth), trans_id width.
- WbPorts, 4, writeback ports.
- CommitPorts, 2, commit ports; 1..Depth.
- NumRs, 2, source lookup ports.
- PayloadW, 64, opaque per-instruction payload carried to commit.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all entries
- alloc_valid  in  1  decode offers instruction
- alloc_ready  out  1  entry available
- alloc_rd  in  5  destination register
- alloc_we  in  1  instruction writes rd
- alloc_payload  in  PayloadW  opaque data
- alloc_id  out  IdxW  trans_id assigned (= tail pointer)
- wb_valid  in  WbPorts  writeback strobe
- wb_idx  in  WbPorts*IdxW  target trans_id
- wb_data  in  WbPorts*32  result
- wb_exc  in  WbPorts  result carries exception
- commit_valid  out  CommitPorts  head+k entry complete
- commit_ack  in  CommitPorts  commit stage retires port k
- commit_id  out  CommitPorts*IdxW  trans_id per port
- commit_rd / commit_we / commit_data / commit_exc / commit_payload  out  per port  entry fields
- rs_addr  in  NumRs*5  source register
- rs_hit  out  NumRs  in-flight producer exists
- rs_id  out  NumRs*IdxW  producer trans_id
- rs_rdy  out  NumRs  producer result available
- rs_data  out  NumRs*32  producer result

Behaviour:
- Reset (async, active-high) and flush both set head = tail = 0, count = 0, and clear every entry's issued/done/exc bits.
- Reset output values: alloc_ready = 1, alloc_id = 0, commit_valid = 0, rs_hit = 0, rs_rdy = 0.
- Occupancy:
  - count is IdxW+1 bits; full when count == Depth.
  - alloc_ready = !full && !flush. It depends only on registered state and flush, never on alloc_valid.
- Allocate:
  - Fires on alloc_valid && alloc_ready.
  - Writes entry[tail] with issued = 1, done = 0, exc = 0, plus rd, we, payload.
  - tail increments modulo Depth; alloc_id = tail.
  - Allocation into a slot freed by a same-cycle commit is not possible, because ready was computed from the pre-commit count.
- Writeback:
  - For each port with wb_valid, if entry[wb_idx].issued, set done = 1, data = wb_data and exc = wb_exc.
  - Writeback to a non-issued entry is ignored, covering stale results after a flush.
  - Two ports targeting the same idx in one cycle is illegal; the higher port index wins.
- Commit:
  - commit_valid[k] = entry[head+k].issued && entry[head+k].done && commit_valid[k-1], using registered state.
  - The valid outputs therefore form a contiguous prefix. A same-cycle writeback becomes committable next cycle.
  - commit_ack must be a prefix-subset of commit_valid; otherwise behaviour is undefined, with an assertion in simulation.
  - Acked entries clear issued/done; head advances by popcount(ack), modulo Depth.
  - The block never flushes itself on exc; the commit stage asserts flush.
- Count update: count_n = count + alloc_fire - popcount(ack). Simultaneous alloc and commit are legal and keep count consistent.
- Flush priority: flush overrides alloc, writeback and commit in the same cycle. Its effect is visible next cycle, and alloc_ready is 0 during the flush cycle.
- Lookup (combinational):
  - For each rs port, search issued entries with we = 1 && rd == rs_addr && rs_addr != 0.
  - Search order is youngest to oldest (tail-1 back to head); the first match gives rs_hit/rs_id/rs_rdy(done)/rs_data.
  - rs_addr == 0 always gives hit = 0.
  - An entry being allocated in the current cycle is not visible to the lookup.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: if the matched producer is not done but some wb_valid[p] has wb_idx[p] == rs_id this cycle, then rs_rdy = 1 and rs_data = wb_data[p]. This saves one cycle of operand wait.
- Undefined: the lookup reflects registered state only; the result is seen the cycle after writeback.

Test Plan:
1. Reset, then 8 allocs with alloc_valid = 1 (Depth = 8) -> alloc_id 0..7; alloc_ready drops to 0 after the 8th; a 9th offer is not accepted.
2. Alloc ids 0,1,2; writeback idx 2 (data 0xC), then idx 0 (0xA) -> commit_valid = 01 (id 0 only). Ack, then writeback idx 1 (0xB) -> next cycle commit_valid = 11 with ids 1,2 and data 0xB,0xC.
3. Full scoreboard; same cycle ack 2 entries and alloc_valid -> alloc rejected (ready = 0). Next cycle count = 6, ready = 1, alloc_id = 0 (wrap-around).
4. Alloc x5 writer (id 0), then another x5 writer (id 1) -> rs_addr = 5 gives hit = 1, id = 1, rdy = 0. rs_addr = 0 gives hit = 0.
5. Alloc 3 entries, assert flush while alloc_valid = 1 and a writeback to idx 1 -> next cycle count = 0, alloc_id = 0, commit_valid = 0. A later writeback to idx 1 is ignored.
6. Assert reset asynchronously mid-stream (between clock edges) -> commit_valid = 0 and alloc_ready = 1 immediately. With SB_WB_BYPASS_EN: writeback to the rs-matched id -> rs_rdy = 1 with wb_data in the same cycle.
